crop_window_ctrl: RTL and testbench

//  Runtime-configurable crop controller between the camera grabber and downstream processing.

---
 rtl/crop_pkg.sv | 19 +
 rtl/crop_pos_counter.sv | 37 +++
 rtl/crop_window_ctrl.sv | 123 ++++++++++++
 tb/tb_crop_window_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/crop_pkg.sv
// crop_pkg: shared widths, window/state types and window legality check for the crop controller
package crop_pkg;
  localparam int PBW = 12;
  localparam int IN_ROWS_D = 40;
  localparam int IN_COLS_D = 40;
  localparam int CW = $clog2(((IN_ROWS_D > IN_COLS_D) ? IN_ROWS_D : IN_COLS_D) + 1);
  typedef struct packed {
    logic [CW-1:0] x1;
    logic [CW-1:0] y1;
    logic [CW-1:0] w;
    logic [CW-1:0] h;
  } win_t;
  typedef enum logic {WAIT_SOF, RUN} state_t;
  // A window is legal when non-empty and fully inside the input frame
  function automatic logic win_valid(win_t win, int rows, int cols);
    return win.w != '0 && win.h != '0 &&
           (int'(win.x1) + int'(win.w) <= cols) && (int'(win.y1) + int'(win.h) <= rows);
  endfunction
endpackage

// File: rtl/crop_pos_counter.sv
// crop_pos_counter: row/col tracking with wrap, start-of-frame resync and frame-end detection
module crop_pos_counter import crop_pkg::*; #(
  parameter int ROWS = IN_ROWS_D,
  parameter int COLS = IN_COLS_D
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_adv,
  input  logic          i_sof,
  output logic [CW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_frame_end,
  output logic          o_sync_err
);
  logic [CW-1:0] r_row, r_col;
  logic w_resync, w_col_wrap, w_row_wrap;
  // A start-of-frame pixel is always position (0,0), whatever the counters held
  always_comb begin
    w_resync = i_adv && i_sof;
    o_sync_err = w_resync && (r_row != '0 || r_col != '0);
    o_row = w_resync ? '0 : r_row;
    o_col = w_resync ? '0 : r_col;
    w_col_wrap = o_col == CW'(COLS - 1);
    w_row_wrap = o_row == CW'(ROWS - 1);
    o_frame_end = i_adv && w_col_wrap && w_row_wrap;
  end
  // Advance past the current pixel's effective position
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_adv) begin
      r_col <= w_col_wrap ? '0 : o_col + 1'b1;
      r_row <= w_col_wrap ? (w_row_wrap ? '0 : o_row + 1'b1) : o_row;
    end
  end
endmodule

// File: rtl/crop_window_ctrl.sv
// crop_window_ctrl: frame-synchronised crop window with boundary-applied config; optional CROP_FRAME_CNT_EN output frame counter
module crop_window_ctrl import crop_pkg::*; #(
  parameter int PIXEL_BIT_WIDTH = PBW,
  parameter int IN_ROWS = IN_ROWS_D,
  parameter int IN_COLS = IN_COLS_D,
  parameter int DEF_Y1 = 10,
  parameter int DEF_X1 = 10,
  parameter int DEF_H = 20,
  parameter int DEF_W = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
  input  logic                       in_sof,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sof,
  output logic                       out_eol,
  output logic                       out_eof,
  input  logic                       cfg_valid,
  input  logic [CW-1:0]              cfg_x1,
  input  logic [CW-1:0]              cfg_y1,
  input  logic [CW-1:0]              cfg_w,
  input  logic [CW-1:0]              cfg_h,
  output logic                       cfg_err,
  output logic                       sync_err,
  output logic [15:0]                frame_cnt
);
  state_t r_state, w_next;
  win_t r_active, r_pend, w_win;
  logic r_pend_vld, r_cfg_err, r_sync_err, r_out_valid, r_sof, r_eol, r_eof;
  logic [PIXEL_BIT_WIDTH-1:0] r_pixel;
  logic w_acc, w_run, w_adv, w_sync_err, w_frame_end, w_pre_apply, w_apply, w_new_ok, w_keep;
  logic w_at_x_end, w_at_y_end;
  logic [CW-1:0] w_row, w_col;
  logic [CW:0] w_x_end, w_y_end;
  assign in_ready = !r_out_valid || out_ready;
  assign w_acc = in_valid && in_ready;
  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= WAIT_SOF;
    else r_state <= w_next;
  end
  // FSM next state: leave WAIT_SOF on the first accepted start-of-frame pixel
  always_comb w_next = (r_state == WAIT_SOF && w_acc && in_sof) ? RUN : r_state;
  // FSM outputs
  always_comb w_run = r_state == RUN;
  assign w_adv = w_acc && (w_run || in_sof);
  crop_pos_counter #(.ROWS(IN_ROWS), .COLS(IN_COLS)) u_pos (
    .clk(clk), .reset(reset), .i_adv(w_adv), .i_sof(in_sof),
    .o_row(w_row), .o_col(w_col), .o_frame_end(w_frame_end), .o_sync_err(w_sync_err)
  );
  // Frame entry and resync apply the pending window before the pixel's keep test; frame end applies after
  always_comb begin
    w_pre_apply = w_adv && (!w_run || w_sync_err);
    w_apply = w_pre_apply || w_frame_end;
    w_new_ok = win_valid(r_pend, IN_ROWS, IN_COLS);
    w_win = (w_pre_apply && r_pend_vld && w_new_ok) ? r_pend : r_active;
    w_x_end = {1'b0, w_win.x1} + {1'b0, w_win.w};
    w_y_end = {1'b0, w_win.y1} + {1'b0, w_win.h};
    w_keep = w_adv && w_row >= w_win.y1 && {1'b0, w_row} < w_y_end &&
             w_col >= w_win.x1 && {1'b0, w_col} < w_x_end;
    w_at_x_end = {1'b0, w_col} == w_x_end - 1'b1;
    w_at_y_end = {1'b0, w_row} == w_y_end - 1'b1;
  end
  // Config shadow: a write landing on an apply cycle waits for the next boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      r_active <= {CW'(DEF_X1), CW'(DEF_Y1), CW'(DEF_W), CW'(DEF_H)};
      r_pend <= '0;
      r_pend_vld <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_apply && r_pend_vld && !w_new_ok;
      if (w_apply && r_pend_vld && w_new_ok) r_active <= r_pend;
      if (cfg_valid) begin
        r_pend <= {cfg_x1, cfg_y1, cfg_w, cfg_h};
        r_pend_vld <= 1'b1;
      end else if (w_apply) r_pend_vld <= 1'b0;
    end
  end
  // Output register: holds while stalled, otherwise reloads from the current accept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_pixel <= '0;
      r_sof <= 1'b0;
      r_eol <= 1'b0;
      r_eof <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_sync_err <= w_sync_err;
      if (in_ready) begin
        r_out_valid <= w_keep;
        if (w_keep) r_pixel <= pixel_in;
        r_sof <= w_keep && w_row == w_win.y1 && w_col == w_win.x1;
        r_eol <= w_keep && w_at_x_end;
        r_eof <= w_keep && w_at_x_end && w_at_y_end;
      end
    end
  end
  assign out_valid = r_out_valid;
  assign pixel_out = r_pixel;
  assign out_sof = r_sof;
  assign out_eol = r_eol;
  assign out_eof = r_eof;
  assign cfg_err = r_cfg_err;
  assign sync_err = r_sync_err;
`ifdef CROP_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;
  // Count completed output frames at the end-of-frame handshake
  always_ff @(posedge clk) begin
    if (reset) r_frame_cnt <= '0;
    else if (r_out_valid && out_ready && r_eof) r_frame_cnt <= r_frame_cnt + 1'b1;
  end
  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_crop_window_ctrl.sv
// tb_crop_window_ctrl: directed scoreboard bench for crop_window_ctrl
module tb_crop_window_ctrl;
  import crop_pkg::*;
  localparam int C = 40;
  logic clk = 1'b0, reset = 1'b1;
  logic [11:0] pixel_in = '0, pixel_out;
  logic in_sof = 1'b0, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic out_sof, out_eol, out_eof, cfg_valid = 1'b0, cfg_err, sync_err;
  logic [CW-1:0] cfg_x1 = '0, cfg_y1 = '0, cfg_w = '0, cfg_h = '0;
  logic [15:0] frame_cnt;
  int tests = 0, fails = 0, out_cnt = 0, cfg_err_cnt = 0, sync_err_cnt = 0, eof_cnt = 0;
  logic [14:0] q[$];
  logic [14:0] e;
  bit stall = 0;
  win_t win;
  always #5 clk = ~clk;
  crop_window_ctrl dut (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_sof(in_sof), .in_valid(in_valid),
    .in_ready(in_ready), .pixel_out(pixel_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .cfg_valid(cfg_valid),
    .cfg_x1(cfg_x1), .cfg_y1(cfg_y1), .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_err(cfg_err),
    .sync_err(sync_err), .frame_cnt(frame_cnt)
  );
  function automatic win_t mk(int x, int y, int w, int h);
    return {CW'(x), CW'(y), CW'(w), CW'(h)};
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Output monitor: every downstream handshake pops one expected beat
  always @(negedge clk) begin
    if (cfg_err) cfg_err_cnt++;
    if (sync_err) sync_err_cnt++;
    if (out_valid && out_ready) begin
      out_cnt++;
      if (out_eof) eof_cnt++;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $error("FAIL unexpected_out: got pixel %0h sof/eol/eof %b%b%b expected no output", pixel_out, out_sof, out_eol, out_eof);
      end else begin
        e = q.pop_front();
        assert ({pixel_out, out_sof, out_eol, out_eof} === e) else begin
          fails++;
          $error("FAIL out_beat: got %0h expected %0h", {pixel_out, out_sof, out_eol, out_eof}, e);
        end
      end
    end
  end
  task automatic px(input logic [11:0] p, input bit s, input int idx);
    bit acc = 0;
    int budget = 0;
    int r = idx / C, c = idx % C;
    int x1 = int'(win.x1), y1 = int'(win.y1), w = int'(win.w), h = int'(win.h);
    pixel_in = p;
    in_sof = s;
    in_valid = 1'b1;
    do begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      acc = in_ready;
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      budget++;
    end while (!acc && budget < 200);
    in_valid = 1'b0;
    in_sof = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
    else if (idx >= 0 && r >= y1 && r < y1 + h && c >= x1 && c < x1 + w)
      q.push_back({p, r == y1 && c == x1, c == x1 + w - 1, r == y1 + h - 1 && c == x1 + w - 1});
  endtask
  task automatic frame(input int n, input int cfg_at, input win_t cw);
    for (int i = 0; i < n; i++) begin
      if (i == cfg_at) begin
        {cfg_x1, cfg_y1, cfg_w, cfg_h} = cw;
        cfg_valid = 1'b1;
      end
      px(12'($urandom), i == 0, i);
    end
  endtask
  task automatic drain(input string tag, input int exp_cnt);
    int k = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    @(posedge clk);
    #1;
    chk({tag, "_drain"}, q.size(), 0);
    chk({tag, "_count"}, out_cnt, exp_cnt);
    out_cnt = 0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    out_cnt = 0;
    eof_cnt = 0;
    win = mk(10, 10, 20, 20);
  endtask
  initial begin
    win = mk(10, 10, 20, 20);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pixel_out", pixel_out, 0);
    chk("rst_flags", {out_sof, out_eol, out_eof}, 0);
    chk("rst_errs", {cfg_err, sync_err}, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) px(12'($urandom), 1'b0, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("junk_no_output", out_cnt, 0);
    frame(1600, -1, '0);
    drain("default_frame", 400);
    chk("eof_once", eof_cnt, 1);
    frame(1600, 500, mk(30, 10, 20, 20));
    drain("bad_cfg_frame", 400);
    chk("cfg_err_pulse", cfg_err_cnt, 1);
    frame(1600, -1, '0);
    drain("after_bad_cfg", 400);
    stall = 1;
    frame(1600, -1, '0);
    stall = 0;
    drain("backpressure", 400);
    frame(1600, 800, mk(0, 0, 40, 40));
    drain("pre_full_cfg", 400);
    win = mk(0, 0, 40, 40);
    frame(1600, -1, '0);
    drain("full_window", 1600);
    chk("no_new_cfg_err", cfg_err_cnt, 1);
    chk("no_sync_err_yet", sync_err_cnt, 0);
    do_reset();
    frame(700, -1, '0);
    drain("partial_700", 150);
    frame(1600, -1, '0);
    drain("after_resync", 400);
    chk("sync_err_pulse", sync_err_cnt, 1);
    frame(452, -1, '0);
    chk("mid_window_valid", out_valid, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_pixel_out", pixel_out, 0);
    chk("midrst_flags", {out_sof, out_eol, out_eof}, 0);
    reset = 1'b0;
    q.delete();
    out_cnt = 0;
    eof_cnt = 0;
    win = mk(10, 10, 20, 20);
    frame(1600, -1, '0);
    drain("post_reset_frame", 400);
`ifdef CROP_FRAME_CNT_EN
    chk("frame_cnt", frame_cnt, eof_cnt);
`else
    chk("frame_cnt", frame_cnt, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
